ctrl_stage_pipe: RTL and testbench
==================================

Name: ctrl_stage_pipe

Overview:
- Parametrised control-bundle pipeline for the MIPS core.
- Carries a decoded control word from D through NSTAGE downstream stages (default E/M/W), with a valid bit and an in-delay-slot flag per stage.
- Per-stage stall/flush and automatic bubble insertion.
- Replaces fixed per-signal E/M/W flop chains; the decoder drives one packed bundle in, and each stage slice is unpacked by consumers.

Parameters:
- CW, 16, width of the packed control bundle.
- NSTAGE, 3, number of registered stages after D (index 0 = E, NSTAGE-1 = final/W); legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ctrlD  in  CW  decoded control bundle of the instruction in D.
- validD  in  1  D holds a real instruction.
- branchD  in  1  D instruction is a branch/jump class (b*, j, jal, jr, jalr, bal); the next instruction is a delay slot.
- stallD  in  1  D stage stalled.
- flushD  in  1  D stage flushed (exception/eret); clears delay-slot tracking.
- stall  in  NSTAGE  per-stage stall, bit k = stage k.
- flush  in  NSTAGE  per-stage flush, bit k = stage k.
- ctrl_q  out  NSTAGE*CW  stage k bundle at bits [k*CW +: CW].
- valid_q  out  NSTAGE  per-stage valid.
- dslot_q  out  NSTAGE  per-stage in-delay-slot flag (for CP0 BD/EPC).
- dslotD  out  1  instruction currently in D is in a delay slot.
- retire_cnt  out  32  count of valid instructions entering final stage (see Optional Feature).

Behaviour:
- Reset: rst==0 at a rising edge → all ctrl_q, valid_q, dslot_q = 0; internal last_br = 0; retire_cnt = 0. Reset has priority over every other input and takes effect mid-operation in one cycle.
- Upstream of stage 0 is D: bundle = validD ? ctrlD : 0, valid = validD, dslot = dslotD; upstream stall = stallD.
- Upstream of stage k>0 is stage k-1 register contents; upstream stall = stall[k-1].
- Per-stage update at each edge, in priority order:
  1. flush[k] → bundle 0, valid 0, dslot 0.
  2. else stall[k] → hold.
  3. else upstream stall → bubble (bundle 0, valid 0, dslot 0).
  4. else load upstream.
- An invalid entry always carries an all-zero bundle, so write enables in bubbles are 0.
- Latency: an unstalled instruction appears in stage k exactly k+1 cycles after being presented in D.
- Delay-slot tracking:
  - accept = validD & ~stallD & ~stall[0] & ~flush[0].
  - On accept, last_br <= branchD.
  - flushD=1 → last_br <= 0, with priority over accept.
  - dslotD = last_br & validD (combinational).
- Simultaneous flush[k] and stall[k]: flush wins.
- Simultaneous stall[k] and upstream stall: hold (no bubble).
- Stalling stage k while stage k+1 is free produces exactly one bubble per stalled cycle in k+1.
- Outputs are direct register outputs except dslotD.
- No combinational path from stall/flush to ctrl_q.

Optional Feature:
- Macro CTRL_PIPE_RETIRE_CNT_EN.
- Defined: 32-bit counter increments by 1 on each edge where stage NSTAGE-1 loads an entry with valid=1 (rule 4 with upstream valid). Hold, bubble and flush do not count. Wraps 0xFFFFFFFF → 0. Cleared by reset.
- Undefined: retire_cnt tied to 0, no counter flops.

Test Plan:
- Reset and fill: rst=0 for 2 cycles, then rst=1; ctrlD=0x00A5, validD=1, no stall/flush, NSTAGE=3 → ctrl_q slice 0 = 0x00A5 after 1 edge, slice 2 after 3 edges; valid_q=3'b111 by edge 3. Assert rst=0 mid-stream → all outputs 0 next edge.
- Stall bubble: stream 0x0001, 0x0002, 0x0003; assert stall[0]=1 for 2 cycles while 0x0002 is in E → E holds 0x0002; M receives 2 bubbles (valid 0, bundle 0x0000); then 0x0002 reaches M, then 0x0003 follows with no loss or duplication.
- Flush priority: flush[1]=1 and stall[1]=1 on the same cycle with M=0x0BEE valid → M becomes 0x0000, valid_q[1]=0; E is unaffected.
- Delay slot: branchD=1 on 0x0010, then 0x0020 → dslotD=1 while 0x0020 is in D; dslot_q[0]=1 when it reaches E and propagates to W. Repeat with flushD=1 between the two → dslotD=0.
- Stall on branch: branch accepted, then stallD=1 for 3 cycles with the slot instruction in D → dslotD stays 1 for all 3 cycles; last_br only updates on accept.
- Retire counter (macro on): 10 valid instructions, with 1 flushed at M and 2 stall bubbles → retire_cnt=9. Preload counter to 0xFFFFFFFF via 2^32 force in bench, retire one → 0x00000000. Macro off → retire_cnt=0 throughout.

Source files
------------

// File: rtl/ctrl_stage_pipe.sv
// ctrl_stage_pipe: carries the decoded control bundle from D through NSTAGE
// registered stages (0 = E ... NSTAGE-1 = final/W). Each stage holds a bundle,
// a valid bit and an in-delay-slot flag, with per-stage stall/flush and
// automatic bubble insertion. Invalid entries always carry an all-zero bundle.
// Optional feature: define CTRL_PIPE_RETIRE_CNT_EN to build the 32-bit retire
// counter; otherwise retire_cnt is tied to zero.
module ctrl_stage_pipe #(
  parameter int unsigned CW     = 16,
  parameter int unsigned NSTAGE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        ctrlD,
  input  logic                 validD,
  input  logic                 branchD,
  input  logic                 stallD,
  input  logic                 flushD,
  input  logic [NSTAGE-1:0]    stall,
  input  logic [NSTAGE-1:0]    flush,
  output logic [NSTAGE*CW-1:0] ctrl_q,
  output logic [NSTAGE-1:0]    valid_q,
  output logic [NSTAGE-1:0]    dslot_q,
  output logic                 dslotD,
  output logic [31:0]          retire_cnt
);

  logic [CW-1:0]     r_ctrl [NSTAGE];
  logic [NSTAGE-1:0] r_valid;
  logic [NSTAGE-1:0] r_dslot;
  logic              r_last_br;

  logic [CW-1:0]     w_up_ctrl [NSTAGE];
  logic [NSTAGE-1:0] w_up_valid;
  logic [NSTAGE-1:0] w_up_dslot;
  logic [NSTAGE-1:0] w_up_stall;
  logic [NSTAGE-1:0] w_load;
  logic              w_accept;

  // D's instruction follows a taken-class branch that was accepted into E.
  assign dslotD   = r_last_br & validD;
  assign w_accept = validD & ~stallD & ~stall[0] & ~flush[0];

  // Upstream view of every stage: D feeds stage 0, stage k-1 feeds stage k.
  always_comb begin
    w_up_ctrl[0]  = validD ? ctrlD : '0;
    w_up_valid[0] = validD;
    w_up_dslot[0] = dslotD;
    w_up_stall[0] = stallD;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      w_up_ctrl[k]  = r_ctrl[k-1];
      w_up_valid[k] = r_valid[k-1];
      w_up_dslot[k] = r_dslot[k-1];
      w_up_stall[k] = stall[k-1];
    end
  end

  // A stage loads its upstream entry only when neither flushed, stalled nor starved.
  always_comb begin
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      w_load[k] = ~flush[k] & ~stall[k] & ~w_up_stall[k];
    end
  end

  // Stage registers: flush > stall(hold) > upstream stall(bubble) > load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        r_ctrl[k] <= '0;
      end
      r_valid <= '0;
      r_dslot <= '0;
    end else begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        if (flush[k]) begin
          r_ctrl[k]  <= '0;
          r_valid[k] <= 1'b0;
          r_dslot[k] <= 1'b0;
        end else if (stall[k]) begin
          // hold
        end else if (w_up_stall[k]) begin
          r_ctrl[k]  <= '0;
          r_valid[k] <= 1'b0;
          r_dslot[k] <= 1'b0;
        end else begin
          r_ctrl[k]  <= w_up_ctrl[k];
          r_valid[k] <= w_up_valid[k];
          r_dslot[k] <= w_up_dslot[k];
        end
      end
    end
  end

  // Remember whether the last instruction accepted into E was a branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_br <= 1'b0;
    end else if (flushD) begin
      r_last_br <= 1'b0;
    end else if (w_accept) begin
      r_last_br <= branchD;
    end
  end

  // Flatten stage bundles onto the packed output bus.
  always_comb begin
    ctrl_q = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      ctrl_q[k*CW +: CW] = r_ctrl[k];
    end
  end

  assign valid_q = r_valid;
  assign dslot_q = r_dslot;

`ifdef CTRL_PIPE_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count valid entries loaded into the final stage; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (w_load[NSTAGE-1] && w_up_valid[NSTAGE-1]) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_stage_pipe.sv
// Bench for ctrl_stage_pipe: directed vectors with literal expectations plus a
// behavioural model of the stage entries checked after every clock edge.
module tb_ctrl_stage_pipe;

  localparam int unsigned CW = 16;
  localparam int unsigned NS = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [CW-1:0]  ctrlD;
  logic           validD, branchD, stallD, flushD;
  logic [NS-1:0]  stall, flush;
  logic [NS*CW-1:0] ctrl_q;
  logic [NS-1:0]  valid_q, dslot_q;
  logic           dslotD;
  logic [31:0]    retire_cnt;

  always #5 clk = ~clk;

  ctrl_stage_pipe #(.CW(CW), .NSTAGE(NS)) dut (
    .clk(clk), .rst(rst), .ctrlD(ctrlD), .validD(validD), .branchD(branchD),
    .stallD(stallD), .flushD(flushD), .stall(stall), .flush(flush),
    .ctrl_q(ctrl_q), .valid_q(valid_q), .dslot_q(dslot_q), .dslotD(dslotD),
    .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic          v;
    logic          d;
  } ent_t;

  ent_t        m_st [NS];
  logic        m_last_br;
  logic [31:0] m_ret;
  logic [31:0] m_base = '0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  // Behavioural model: what each stage must hold after an edge.
  always @(posedge clk) begin
    ent_t old [NS];
    ent_t up;
    bit   up_stall;
    old = m_st;
    if (!rst) begin
      for (int k = 0; k < NS; k++) m_st[k] = '0;
      m_last_br = 1'b0;
      m_ret     = '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (k == 0) begin
          up.c     = validD ? ctrlD : '0;
          up.v     = validD;
          up.d     = m_last_br & validD;
          up_stall = stallD;
        end else begin
          up       = old[k-1];
          up_stall = stall[k-1];
        end
        if (flush[k])      m_st[k] = '0;
        else if (stall[k]) m_st[k] = old[k];
        else if (up_stall) m_st[k] = '0;
        else begin
          m_st[k] = up;
          if (k == NS - 1 && up.v) m_ret = m_ret + 32'd1;
        end
      end
      if (flushD) m_last_br = 1'b0;
      else if (validD && !stallD && !stall[0] && !flush[0]) m_last_br = branchD;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_cycle();
    logic [NS*CW-1:0] ec;
    logic [NS-1:0]    ev, ed;
    logic [31:0]      er;
    for (int k = 0; k < NS; k++) begin
      ec[k*CW +: CW] = m_st[k].c;
      ev[k]          = m_st[k].v;
      ed[k]          = m_st[k].d;
    end
`ifdef CTRL_PIPE_RETIRE_CNT_EN
    er = m_base + m_ret;
`else
    er = '0;
`endif
    chk("model ctrl_q", 64'(ctrl_q), 64'(ec));
    chk("model valid_q", 64'(valid_q), 64'(ev));
    chk("model dslot_q", 64'(dslot_q), 64'(ed));
    chk("model dslotD", 64'(dslotD), 64'(m_last_br & validD));
    chk("model retire_cnt", 64'(retire_cnt), 64'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_en) compare_cycle();
  endtask

  initial begin
    rst = 1'b0; ctrlD = '0; validD = 1'b0; branchD = 1'b0;
    stallD = 1'b0; flushD = 1'b0; stall = '0; flush = '0;

    // Reset and fill
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset valid_q", 64'(valid_q), 64'(3'b000));
    chk("reset ctrl_q", 64'(ctrl_q), 64'(48'h0));
    rst = 1'b1; validD = 1'b1; ctrlD = 16'h00A5;
    tick();
    chk("fill E", 64'(ctrl_q[15:0]), 64'(16'h00A5));
    tick();
    tick();
    chk("fill W", 64'(ctrl_q[47:32]), 64'(16'h00A5));
    chk("fill valid", 64'(valid_q), 64'(3'b111));
    rst = 1'b0;
    tick();
    chk("midreset ctrl_q", 64'(ctrl_q), 64'(48'h0));
    chk("midreset valid_q", 64'(valid_q), 64'(3'b000));
    rst = 1'b1; validD = 1'b0;

    // Stall bubble
    validD = 1'b1; ctrlD = 16'h0001; tick();
    ctrlD = 16'h0002; tick();
    ctrlD = 16'h0003; stall = 3'b001;
    tick();
    chk("stall E hold", 64'(ctrl_q[15:0]), 64'(16'h0002));
    chk("stall M bubble1", 64'({valid_q[1], ctrl_q[31:16]}), 64'(17'h0));
    tick();
    chk("stall M bubble2", 64'({valid_q[1], ctrl_q[31:16]}), 64'(17'h0));
    stall = 3'b000;
    tick();
    chk("stall M gets 2", 64'({valid_q[1], ctrl_q[31:16]}), 64'(17'h1_0002));
    validD = 1'b0;
    tick();
    chk("stall W gets 2", 64'(ctrl_q[47:32]), 64'(16'h0002));
    tick();
    chk("stall W gets 3", 64'({valid_q[2], ctrl_q[47:32]}), 64'(17'h1_0003));

    // Flush beats stall
    validD = 1'b1; ctrlD = 16'h0BEE; tick();
    ctrlD = 16'h0C01; tick();
    chk("flush M pre", 64'(ctrl_q[31:16]), 64'(16'h0BEE));
    ctrlD = 16'h0C02; flush = 3'b010; stall = 3'b010;
    tick();
    chk("flush M", 64'({valid_q[1], ctrl_q[31:16]}), 64'(17'h0));
    chk("flush E ok", 64'({valid_q[0], ctrl_q[15:0]}), 64'(17'h1_0C02));
    flush = '0; stall = '0; validD = 1'b0;
    tick();

    // Delay slot
    validD = 1'b1; ctrlD = 16'h0010; branchD = 1'b1;
    tick();
    ctrlD = 16'h0020; branchD = 1'b0;
    #1;
    chk("dslotD after br", 64'(dslotD), 64'(1'b1));
    tick();
    chk("dslot E", 64'({dslot_q[0], ctrl_q[15:0]}), 64'(17'h1_0020));
    validD = 1'b0;
    tick();
    tick();
    chk("dslot W", 64'({dslot_q[2], ctrl_q[47:32]}), 64'(17'h1_0020));
    validD = 1'b1; ctrlD = 16'h0010; branchD = 1'b1;
    tick();
    validD = 1'b0; branchD = 1'b0; flushD = 1'b1;
    tick();
    flushD = 1'b0; validD = 1'b1; ctrlD = 16'h0020;
    #1;
    chk("dslotD flushed", 64'(dslotD), 64'(1'b0));
    tick();
    chk("dslot E flushed", 64'({dslot_q[0], valid_q[0]}), 64'(2'b01));

    // Stall on branch
    ctrlD = 16'h0030; branchD = 1'b1;
    tick();
    ctrlD = 16'h0040; branchD = 1'b0; stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dslotD stalled", 64'({dslotD, valid_q[0]}), 64'(2'b10));
    end
    stallD = 1'b0;
    tick();
    chk("dslot E after stall", 64'({dslot_q[0], ctrl_q[15:0]}), 64'(17'h1_0040));
    validD = 1'b0;
    tick();

    // Mixed directed pattern, checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      validD  = (i % 5) != 4;
      ctrlD   = CW'(32'h1000 + 32'(i));
      branchD = (i % 7) == 2;
      stallD  = (i % 11) == 5;
      flushD  = (i % 13) == 9;
      stall   = (i % 6 == 3) ? 3'b001 : (i % 9 == 4) ? 3'b010 : (i % 10 == 7) ? 3'b110 : 3'b000;
      flush   = (i % 8 == 6) ? 3'b100 : (i % 12 == 1) ? 3'b011 : 3'b000;
      tick();
    end
    validD = 1'b0; branchD = 1'b0; stallD = 1'b0; flushD = 1'b0; stall = '0; flush = '0;

    // Retire counter: 10 instructions, 2 stall bubbles, one flushed at M
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      validD = 1'b1;
      ctrlD  = CW'(32'h0100 + 32'(i));
      if (i == 4) begin
        stall = 3'b001;
        tick();
        tick();
        stall = 3'b000;
      end
      if (i == 7) flush = 3'b010;
      tick();
      flush = 3'b000;
    end
    validD = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`ifdef CTRL_PIPE_RETIRE_CNT_EN
    chk("retire count", 64'(retire_cnt), 64'(32'd9));
    m_base = 32'hFFFF_FFFF - m_ret;
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
`else
    chk("retire off", 64'(retire_cnt), 64'(32'd0));
`endif
    validD = 1'b1; ctrlD = 16'h0777;
    tick();
    validD = 1'b0;
    tick();
    tick();
    chk("retire wrap", 64'(retire_cnt), 64'(32'd0));
    chk("retire W", 64'({valid_q[2], ctrl_q[47:32]}), 64'(17'h1_0777));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
